// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a clamped cursor position and button states.
// Also resynchronises on stalled partial packets and counts how many were dropped.
module mouse_packet_tracker #(
    parameter int H_RES          = 800,
    parameter int V_RES          = 600,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        recenter,
    output logic [11:0] mouse_xpos,
    output logic [11:0] mouse_ypos,
    output logic        left_mouse,
    output logic        right_mouse,
    output logic        packet_stb,
    output logic [7:0]  resync_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]        X_CTR   = 12'(H_RES / 2);
    localparam logic [11:0]        Y_CTR   = 12'(V_RES / 2);
    localparam logic signed [13:0] X_MAX   = 14'(H_RES - 1);
    localparam logic signed [13:0] Y_MAX   = 14'(V_RES - 1);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

    state_t           r_state, w_next_state;
    logic [7:0]       r_b0, r_b1, r_b2;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [11:0]      r_xpos, r_ypos;
    logic             r_left, r_right, r_pkt_stb;
    logic [7:0]       r_resync_cnt;

    logic             w_store_b0, w_store_b1, w_store_b2, w_update, w_timeout, w_in_pkt;
    logic signed [13:0] w_dx, w_dy, w_nx, w_ny;

    function automatic logic [11:0] clamp_pos(input logic signed [13:0] v,
                                              input logic signed [13:0] max_v);
        if (v < 14'sd0)
            return 12'd0;
        else if (v > max_v)
            return max_v[11:0];
        else
            return v[11:0];
    endfunction

    assign w_in_pkt  = (r_state == WAIT_B1) || (r_state == WAIT_B2);
    assign w_timeout = w_in_pkt && !rx_valid && (r_idle_cnt == TO_LAST);

    // Overflow flags zero the affected delta; buttons are never masked.
    assign w_dx = r_b0[6] ? 14'sd0 : $signed({{6{r_b0[4]}}, r_b1});
    assign w_dy = r_b0[7] ? 14'sd0 : $signed({{6{r_b0[5]}}, r_b2});
    assign w_nx = $signed({2'b00, r_xpos}) + w_dx;
    assign w_ny = $signed({2'b00, r_ypos}) - w_dy;

    always_comb begin
        w_next_state = r_state;
        w_store_b0   = 1'b0;
        w_store_b1   = 1'b0;
        w_store_b2   = 1'b0;
        w_update     = 1'b0;
        case (r_state)
            WAIT_B0: begin
                if (rx_valid && rx_data[3]) begin
                    w_store_b0   = 1'b1;
                    w_next_state = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (rx_valid) begin
                    w_store_b1   = 1'b1;
                    w_next_state = WAIT_B2;
                end else if (w_timeout) begin
                    w_next_state = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (rx_valid) begin
                    w_store_b2   = 1'b1;
                    w_next_state = UPDATE;
                end else if (w_timeout) begin
                    w_next_state = WAIT_B0;
                end
            end
            UPDATE: begin
                w_update = 1'b1;
                if (rx_valid && rx_data[3]) begin
                    w_store_b0   = 1'b1;
                    w_next_state = WAIT_B1;
                end else begin
                    w_next_state = WAIT_B0;
                end
            end
            default: w_next_state = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store_b0) r_b0 <= rx_data;
        if (w_store_b1) r_b1 <= rx_data;
        if (w_store_b2) r_b2 <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_B0;
            r_idle_cnt   <= '0;
            r_xpos       <= X_CTR;
            r_ypos       <= Y_CTR;
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_pkt_stb    <= 1'b0;
            r_resync_cnt <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_pkt_stb <= w_update;

            if (rx_valid || !w_in_pkt || w_timeout)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 1'b1;

            if (w_timeout && (r_resync_cnt != 8'hFF))
                r_resync_cnt <= r_resync_cnt + 8'd1;

            // Recenter overrides a packet's movement but not its buttons.
            if (recenter) begin
                r_xpos <= X_CTR;
                r_ypos <= Y_CTR;
            end else if (w_update) begin
                r_xpos <= clamp_pos(w_nx, X_MAX);
                r_ypos <= clamp_pos(w_ny, Y_MAX);
            end

            if (w_update) begin
                r_left  <= r_b0[0];
                r_right <= r_b0[1];
            end
        end
    end

    assign mouse_xpos  = r_xpos;
    assign mouse_ypos  = r_ypos;
    assign left_mouse  = r_left;
    assign right_mouse = r_right;
    assign packet_stb  = r_pkt_stb;
    assign resync_cnt  = r_resync_cnt;

endmodule
